// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// mdu_unit : multi-cycle multiply/divide unit owning architectural HI/LO.
// Optional feature macro MDU_MADD_EN enables madd/maddu/msub/msubu.
// Revision : 1.0
// ============================================================================
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  mdu_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mdu_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [3:0] C_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic        wr_q, wr_d;

  // Sign-extend to 64 bits so one unsigned multiplier serves both signednesses.
  logic        w_mul_signed;
  logic [63:0] w_mul_a, w_mul_b, w_prod;

`ifdef MDU_MADD_EN
  assign w_mul_signed = (mdu_op == OP_MULT) || (mdu_op == OP_MADD) || (mdu_op == OP_MSUB);
`else
  assign w_mul_signed = (mdu_op == OP_MULT);
`endif
  assign w_mul_a = {{32{a[31] & w_mul_signed}}, a};
  assign w_mul_b = {{32{b[31] & w_mul_signed}}, b};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed division on magnitudes avoids the INT_MIN / -1 overflow corner.
  logic        w_div_signed, w_neg_a, w_neg_b;
  logic [31:0] w_dvd, w_dvs, w_uq, w_ur, w_quot, w_rem;

  assign w_div_signed = (mdu_op == OP_DIV);
  assign w_neg_a      = w_div_signed & a[31];
  assign w_neg_b      = w_div_signed & b[31];
  assign w_dvd        = w_neg_a ? (32'd0 - a) : a;
  assign w_dvs        = (b == 32'd0) ? 32'd1 : (w_neg_b ? (32'd0 - b) : b);
  assign w_uq         = w_dvd / w_dvs;
  assign w_ur         = w_dvd % w_dvs;
  assign w_quot       = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
  assign w_rem        = w_neg_a ? (32'd0 - w_ur) : w_ur;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = ((mdu_op == OP_MSUB) || (mdu_op == OP_MSUBU)) ?
                 ({hi_q, lo_q} - w_prod) : ({hi_q, lo_q} + w_prod);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    wr_d     = wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT, OP_MULTU: begin
              {tmp_hi_d, tmp_lo_d} = w_prod;
              wr_d    = 1'b1;
              cnt_d   = C_MULT_N;
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              tmp_hi_d = w_rem;
              tmp_lo_d = w_quot;
              wr_d     = (b != 32'd0);
              cnt_d    = C_DIV_N;
              state_d  = S_BUSY;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              {tmp_hi_d, tmp_lo_d} = w_acc;
              wr_d    = 1'b1;
              cnt_d   = C_MULT_N;
              state_d = S_BUSY;
            end
`endif
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          if (wr_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      wr_q     <= wr_d;
    end
  end

  assign busy    = (state_q == S_BUSY);
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign mdu_out = (mdu_op == OP_MFHI) ? hi_q :
                   (mdu_op == OP_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// tb_mdu_unit : directed + randomized bench for mdu_unit against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_mdu_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  mdu_op = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi_out, lo_out, mdu_out;

  mdu_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .mdu_op (mdu_op),
    .start  (start),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: architectural HI/LO, a pending result and the edge index at which it lands.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0;
  longint      cyc = 0, done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit st, input logic [3:0] op,
                            input logic [31:0] x, input logic [31:0] y);
    bit          was_busy;
    logic [63:0] r;
    longint      sa, sb, q, rm, sp;
    int          n;
    was_busy = (cyc < done_cyc);
    cyc++;
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; p_wr = 1'b0; done_cyc = cyc;
      return;
    end
    if (was_busy) begin
      if (cyc == done_cyc && p_wr) begin
        m_hi = p_hi; m_lo = p_lo;
      end
      return;
    end
    if (!st) return;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    sp = sa * sb;
    n  = 0;
    r  = '0;
    p_wr = 1'b1;
    case (op)
      4'd1: begin r = sp; n = MULT_CYCLES; end
      4'd2: begin r = {32'd0, x} * {32'd0, y}; n = MULT_CYCLES; end
      4'd3: begin
        n = DIV_CYCLES;
        if (y == 0) p_wr = 1'b0;
        else begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      end
      4'd4: begin
        n = DIV_CYCLES;
        if (y == 0) p_wr = 1'b0;
        else r = {x % y, x / y};
      end
      4'd5: m_hi = x;
      4'd6: m_lo = x;
`ifdef MDU_MADD_EN
      4'd9:  begin r = {m_hi, m_lo} + sp; n = MULT_CYCLES; end
      4'd10: begin r = {m_hi, m_lo} + ({32'd0, x} * {32'd0, y}); n = MULT_CYCLES; end
      4'd11: begin r = {m_hi, m_lo} - sp; n = MULT_CYCLES; end
      4'd12: begin r = {m_hi, m_lo} - ({32'd0, x} * {32'd0, y}); n = MULT_CYCLES; end
`endif
      default: ;
    endcase
    if (n > 0) begin
      {p_hi, p_lo} = r;
      done_cyc = cyc + n;
    end
  endtask

  // One clock: drive at negedge, compare against model state, then advance model at posedge.
  task automatic step(input bit rst_n, input bit st, input logic [3:0] op,
                      input logic [31:0] x, input logic [31:0] y);
    logic [31:0] exp_out;
    @(negedge clk);
    reset = rst_n; start = st; mdu_op = op; a = x; b = y;
    #1;
    exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    check("busy", {31'd0, busy}, {31'd0, (cyc < done_cyc)});
    check("hi", hi_out, m_hi);
    check("lo", lo_out, m_lo);
    check("mdu_out", mdu_out, exp_out);
    @(posedge clk);
    model_edge(rst_n, st, op, x, y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    cyc = 0; done_cyc = 0;

    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

    // mult signed: -1 * 2
    step(1'b1, 1'b1, 4'd1, 32'hFFFF_FFFF, 32'd2);
    idle(4);
    #1 check("t1_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    #1 check("t1_busy_done", {31'd0, busy}, 32'd0);
    check("t1_hi", hi_out, 32'hFFFF_FFFF);
    check("t1_lo", lo_out, 32'hFFFF_FFFE);

    // multu
    step(1'b1, 1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2);
    idle(5);
    #1 check("t2_hi", hi_out, 32'h0000_0001);
    check("t2_lo", lo_out, 32'hFFFF_FFFE);

    // div -7/2, then divu by zero
    step(1'b1, 1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    #1 check("t3_lo", lo_out, 32'hFFFF_FFFD);
    check("t3_hi", hi_out, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 4'd4, 32'd7, 32'd0);
    idle(9);
    #1 check("t3_dz_busy", {31'd0, busy}, 32'd1);
    idle(1);
    #1 check("t3_dz_lo", lo_out, 32'hFFFF_FFFD);
    check("t3_dz_hi", hi_out, 32'hFFFF_FFFF);

    // INT_MIN / -1
    step(1'b1, 1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    #1 check("ovf_lo", lo_out, 32'h8000_0000);
    check("ovf_hi", hi_out, 32'd0);

    // mthi then mflo / mfhi
    step(1'b1, 1'b1, 4'd5, 32'h0000_1234, 32'd0);
    #1 check("t4_busy", {31'd0, busy}, 32'd0);
    step(1'b1, 1'b1, 4'd8, 32'd0, 32'd0);
    step(1'b1, 1'b1, 4'd7, 32'd0, 32'd0);
    check("t4_mfhi", mdu_out, 32'h0000_1234);

    // reset aborts a division in flight
    step(1'b1, 1'b1, 4'd3, 32'd100, 32'd3);
    idle(3);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    #1 check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_hi", hi_out, 32'd0);
    check("t5_lo", lo_out, 32'd0);
    idle(12);
    #1 check("t5_late_lo", lo_out, 32'd0);

    // maddu carry into HI
    step(1'b1, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'd0);
    step(1'b1, 1'b1, 4'd10, 32'd1, 32'd1);
    idle(5);
`ifdef MDU_MADD_EN
    #1 check("t6_hi", hi_out, 32'd1);
    check("t6_lo", lo_out, 32'd0);
`else
    #1 check("t6_hi", hi_out, 32'd0);
    check("t6_lo", lo_out, 32'hFFFF_FFFF);
`endif

    // Randomized traffic, including starts while busy and rare resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(299) != 0), $urandom_range(1) != 0,
           4'($urandom_range(12)), pick(), pick());
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
